// File: rtl/uma_pkg.sv
// Shared definitions for the unified memory arbiter: requester ids and parameter checks.
// UMA_DBG_PORT_EN selects whether the debug port takes part in arbitration.
package uma_pkg;

  typedef enum logic [1:0] {
    OWN_IF  = 2'd0,
    OWN_MEM = 2'd1,
    OWN_DBG = 2'd2
  } own_e;

  localparam int UMA_AW_DEF = 8;
  localparam int UMA_NREQ   = 3;

  // Only single- and double-cycle RAM read latencies are supported.
  function automatic bit ram_lat_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

`ifdef UMA_DBG_PORT_EN
  localparam own_e LAST_GNT_RST = OWN_DBG;
`else
  localparam own_e LAST_GNT_RST = OWN_MEM;
`endif

endpackage

// File: rtl/uma_rr_pick.sv
// Combinational 3-way round-robin picker: search starts at the requester after i_last.
// Order is IF -> MEM -> DBG -> IF; an out-of-range i_last restarts the search at IF.
module uma_rr_pick
  import uma_pkg::*;
(
  input  logic [2:0] i_req,
  input  own_e       i_last,
  output logic [2:0] o_gnt,
  output own_e       o_owner,
  output logic       o_any
);

  own_e w_first;
  own_e w_second;
  own_e w_third;

  always_comb begin
    w_first  = OWN_IF;
    w_second = OWN_MEM;
    w_third  = OWN_DBG;
    case (i_last)
      OWN_IF: begin
        w_first  = OWN_MEM;
        w_second = OWN_DBG;
        w_third  = OWN_IF;
      end
      OWN_MEM: begin
        w_first  = OWN_DBG;
        w_second = OWN_IF;
        w_third  = OWN_MEM;
      end
      default: ;
    endcase
  end

  always_comb begin
    o_gnt   = 3'b000;
    o_owner = OWN_IF;
    o_any   = 1'b0;
    if (i_req[w_first]) begin
      o_any   = 1'b1;
      o_owner = w_first;
    end else if (i_req[w_second]) begin
      o_any   = 1'b1;
      o_owner = w_second;
    end else if (i_req[w_third]) begin
      o_any   = 1'b1;
      o_owner = w_third;
    end
    if (o_any) o_gnt[o_owner] = 1'b1;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous RAM between IF, MEM and DBG requesters.
// Define UMA_DBG_PORT_EN to let the debug port arbitrate; otherwise it is tied off.
module unified_mem_arbiter
  import uma_pkg::*;
#(
  parameter int AW      = UMA_AW_DEF,
  parameter int RAM_LAT = 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          mem_req,
  input  logic [31:0]   mem_addr,
  input  logic [3:0]    mem_wen,
  input  logic [31:0]   mem_wdata,
  output logic          mem_gnt,
  output logic          mem_rvalid,
  output logic [31:0]   mem_rdata,
  input  logic          dbg_req,
  input  logic [31:0]   dbg_addr,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [31:0]   dbg_rdata,
  output logic          ram_en,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata,
  output logic          busy
);

  if (!ram_lat_legal(RAM_LAT)) begin : g_bad_lat
    $error("unified_mem_arbiter: RAM_LAT must be 1 or 2");
  end

  logic       w_dbg_req;
  logic [2:0] w_req;
  logic [2:0] w_pick;
  logic [2:0] w_gnt;
  own_e       w_owner;
  logic       w_any;
  logic       w_grant;
  logic       w_is_wr;
  logic       w_rd_push;
  logic [31:0] w_addr;
  logic       w_unused;

  own_e               r_last_gnt;
  logic [RAM_LAT-1:0] r_pipe_vld;
  own_e               r_pipe_own [RAM_LAT];

`ifdef UMA_DBG_PORT_EN
  assign w_dbg_req = dbg_req;
`else
  assign w_dbg_req = 1'b0;
`endif

  assign w_req = {w_dbg_req, mem_req, if_req};

  uma_rr_pick u_pick (
    .i_req   (w_req),
    .i_last  (r_last_gnt),
    .o_gnt   (w_pick),
    .o_owner (w_owner),
    .o_any   (w_any)
  );

  // Reset gates grants combinationally so nothing reaches the RAM while resetn is low.
  assign w_gnt   = w_pick & {3{resetn}};
  assign w_grant = w_any & resetn;

  assign if_gnt  = w_gnt[OWN_IF];
  assign mem_gnt = w_gnt[OWN_MEM];
`ifdef UMA_DBG_PORT_EN
  assign dbg_gnt = w_gnt[OWN_DBG];
`else
  assign dbg_gnt = 1'b0;
`endif

  always_comb begin
    case (w_owner)
      OWN_MEM: w_addr = mem_addr;
      OWN_DBG: w_addr = dbg_addr;
      default: w_addr = if_addr;
    endcase
  end

  assign w_is_wr   = w_gnt[OWN_MEM] && (mem_wen != 4'b0000);
  assign w_rd_push = w_grant && !w_is_wr;

  assign ram_en    = w_grant;
  assign ram_wen   = w_gnt[OWN_MEM] ? mem_wen : 4'b0000;
  assign ram_addr  = w_addr[AW+1:2];
  assign ram_wdata = mem_wdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_last_gnt <= LAST_GNT_RST;
    end else if (w_grant) begin
      r_last_gnt <= w_owner;
    end
  end

  // Response pipeline: one stage per RAM latency cycle, entry exits with the RAM data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_push;
      for (int i = 1; i < RAM_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_pipe_own[0] <= w_owner;
    for (int i = 1; i < RAM_LAT; i++) begin
      r_pipe_own[i] <= r_pipe_own[i-1];
    end
  end

  assign if_rvalid  = r_pipe_vld[RAM_LAT-1] && (r_pipe_own[RAM_LAT-1] == OWN_IF);
  assign mem_rvalid = r_pipe_vld[RAM_LAT-1] && (r_pipe_own[RAM_LAT-1] == OWN_MEM);
`ifdef UMA_DBG_PORT_EN
  assign dbg_rvalid = r_pipe_vld[RAM_LAT-1] && (r_pipe_own[RAM_LAT-1] == OWN_DBG);
`else
  assign dbg_rvalid = 1'b0;
`endif

  assign if_rdata  = ram_rdata;
  assign mem_rdata = ram_rdata;
  assign dbg_rdata = ram_rdata;

  assign busy = |r_pipe_vld;

`ifdef UMA_DBG_PORT_EN
  assign w_unused = ^{w_addr[31:AW+2], w_addr[1:0]};
`else
  assign w_unused = ^{w_addr[31:AW+2], w_addr[1:0], dbg_req, w_gnt[OWN_DBG]};
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench: two arbiters (RAM_LAT 1 and 2) share stimulus and are compared
// against a cycle-level round-robin/memory model; honours UMA_DBG_PORT_EN.
module tb_unified_mem_arbiter;

`ifdef UMA_DBG_PORT_EN
  localparam bit DBG_EN = 1'b1;
`else
  localparam bit DBG_EN = 1'b0;
`endif
  localparam int BOUND    = DBG_EN ? 3 : 2;
  localparam int RST_LAST = DBG_EN ? 2 : 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        if_req, mem_req, dbg_req;
  logic [31:0] if_addr, mem_addr, dbg_addr, mem_wdata;
  logic [3:0]  mem_wen;
  logic        ram_load;

  int total = 0;
  int bad   = 0;

  logic        d1_if_gnt, d1_mem_gnt, d1_dbg_gnt, d1_if_rv, d1_mem_rv, d1_dbg_rv, d1_en, d1_busy;
  logic [31:0] d1_if_rd, d1_mem_rd, d1_dbg_rd, d1_wdata, d1_ram_rdata;
  logic [3:0]  d1_wen;
  logic [7:0]  d1_addr;
  logic        d2_if_gnt, d2_mem_gnt, d2_dbg_gnt, d2_if_rv, d2_mem_rv, d2_dbg_rv, d2_en, d2_busy;
  logic [31:0] d2_if_rd, d2_mem_rd, d2_dbg_rd, d2_wdata, d2_ram_rdata;
  logic [3:0]  d2_wen;
  logic [7:0]  d2_addr;

  unified_mem_arbiter #(.AW(8), .RAM_LAT(1)) u_dut1 (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(d1_if_gnt), .if_rvalid(d1_if_rv), .if_rdata(d1_if_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_gnt(d1_mem_gnt), .mem_rvalid(d1_mem_rv), .mem_rdata(d1_mem_rd),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(d1_dbg_gnt), .dbg_rvalid(d1_dbg_rv), .dbg_rdata(d1_dbg_rd),
    .ram_en(d1_en), .ram_wen(d1_wen), .ram_addr(d1_addr), .ram_wdata(d1_wdata),
    .ram_rdata(d1_ram_rdata), .busy(d1_busy)
  );

  unified_mem_arbiter #(.AW(8), .RAM_LAT(2)) u_dut2 (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(d2_if_gnt), .if_rvalid(d2_if_rv), .if_rdata(d2_if_rd),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_gnt(d2_mem_gnt), .mem_rvalid(d2_mem_rv), .mem_rdata(d2_mem_rd),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(d2_dbg_gnt), .dbg_rvalid(d2_dbg_rv), .dbg_rdata(d2_dbg_rd),
    .ram_en(d2_en), .ram_wen(d2_wen), .ram_addr(d2_addr), .ram_wdata(d2_wdata),
    .ram_rdata(d2_ram_rdata), .busy(d2_busy)
  );

  logic [2:0]  gv [2];
  logic [2:0]  rv [2];
  logic        en [2];
  logic        bz [2];
  logic [3:0]  wn [2];
  logic [7:0]  ra [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2][3];
  assign gv[0] = {d1_dbg_gnt, d1_mem_gnt, d1_if_gnt};
  assign gv[1] = {d2_dbg_gnt, d2_mem_gnt, d2_if_gnt};
  assign rv[0] = {d1_dbg_rv, d1_mem_rv, d1_if_rv};
  assign rv[1] = {d2_dbg_rv, d2_mem_rv, d2_if_rv};
  assign en[0] = d1_en;    assign en[1] = d2_en;
  assign bz[0] = d1_busy;  assign bz[1] = d2_busy;
  assign wn[0] = d1_wen;   assign wn[1] = d2_wen;
  assign ra[0] = d1_addr;  assign ra[1] = d2_addr;
  assign wd[0] = d1_wdata; assign wd[1] = d2_wdata;
  assign rd[0][0] = d1_if_rd; assign rd[0][1] = d1_mem_rd; assign rd[0][2] = d1_dbg_rd;
  assign rd[1][0] = d2_if_rd; assign rd[1][1] = d2_mem_rd; assign rd[1][2] = d2_dbg_rd;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h12345678;
    if (i == 8) return 32'h11223344;
    return 32'h5A000000 ^ (i * 32'h00010203);
  endfunction

  function automatic int own_of(input logic [2:0] g);
    case (g)
      3'b001: return 0;
      3'b010: return 1;
      3'b100: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] mkaddr(input logic [31:0] r);
    return {r[31:10], 3'b000, r[6:2], r[1:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  // Bench RAMs: lane 1 returns data one cycle after ram_en, lane 2 two cycles after.
  logic [31:0] ram1 [256];
  logic [31:0] ram2 [256];
  logic [31:0] ram2_q0;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) begin
        ram1[i] <= init_word(i);
        ram2[i] <= init_word(i);
      end
    end else begin
      if (d1_en) begin
        d1_ram_rdata <= ram1[d1_addr];
        if (d1_wen[0]) ram1[d1_addr][7:0]   <= d1_wdata[7:0];
        if (d1_wen[1]) ram1[d1_addr][15:8]  <= d1_wdata[15:8];
        if (d1_wen[2]) ram1[d1_addr][23:16] <= d1_wdata[23:16];
        if (d1_wen[3]) ram1[d1_addr][31:24] <= d1_wdata[31:24];
      end
      if (d2_en) begin
        ram2_q0 <= ram2[d2_addr];
        if (d2_wen[0]) ram2[d2_addr][7:0]   <= d2_wdata[7:0];
        if (d2_wen[1]) ram2[d2_addr][15:8]  <= d2_wdata[15:8];
        if (d2_wen[2]) ram2[d2_addr][23:16] <= d2_wdata[23:16];
        if (d2_wen[3]) ram2[d2_addr][31:24] <= d2_wdata[31:24];
      end
      d2_ram_rdata <= ram2_q0;
    end
  end

  // Reference model: expected winner from the rotation rule, memory image, and a
  // cycle-indexed history of granted reads from which responses and busy follow.
  logic [31:0] mm [256];
  initial begin
    int          last, cyc, win, c, lat, wi;
    logic [2:0]  rq, eg, erv;
    logic        wr, ebusy;
    logic [31:0] wa, edata;
    int          eown;
    bit          hv [8];
    int          hc [8];
    int          ho [8];
    logic [31:0] hd [8];
    int          wt [3];
    for (int i = 0; i < 256; i++) mm[i] = init_word(i);
    for (int i = 0; i < 8; i++) begin hv[i] = 0; hc[i] = -1; ho[i] = 0; hd[i] = '0; end
    for (int p = 0; p < 3; p++) wt[p] = 0;
    last = RST_LAST;
    cyc  = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        for (int l = 0; l < 2; l++) begin
          chk("rst_gnt", 32'(gv[l]), 0);
          chk("rst_ram_en", 32'(en[l]), 0);
          chk("rst_ram_wen", 32'(wn[l]), 0);
          chk("rst_rvalid", 32'(rv[l]), 0);
          chk("rst_busy", 32'(bz[l]), 0);
        end
        last = RST_LAST;
        for (int i = 0; i < 8; i++) hv[i] = 0;
        for (int p = 0; p < 3; p++) wt[p] = 0;
      end else begin
        rq  = {DBG_EN && dbg_req, mem_req, if_req};
        win = 3;
        for (int k = 1; k <= 3; k++) begin
          c = (last + k) % 3;
          if (win == 3 && rq[c]) win = c;
        end
        eg = (win == 3) ? 3'b000 : (3'b001 << win);
        wr = (win == 1) && (mem_wen != 4'b0000);
        wa = (win == 1) ? mem_addr : (win == 2) ? dbg_addr : if_addr;
        wi = int'((wa >> 2) & 32'hFF);
        for (int l = 0; l < 2; l++) begin
          lat = l + 1;
          chk("gnt", 32'(gv[l]), 32'(eg));
          chk("ram_en", 32'(en[l]), (win != 3) ? 1 : 0);
          chk("ram_wen", 32'(wn[l]), (win == 1) ? 32'(mem_wen) : 0);
          if (win != 3) chk("ram_addr", 32'(ra[l]), wi);
          if (wr) chk("ram_wdata", wd[l], mem_wdata);
          erv = 3'b000; ebusy = 1'b0; edata = '0; eown = 0;
          for (int d = 1; d <= lat; d++) begin
            if (cyc - d >= 0 && hv[(cyc-d)%8] && hc[(cyc-d)%8] == cyc - d) begin
              ebusy = 1'b1;
              if (d == lat) begin
                eown = ho[(cyc-d)%8];
                erv[eown] = 1'b1;
                edata = hd[(cyc-d)%8];
              end
            end
          end
          chk("rvalid", 32'(rv[l]), 32'(erv));
          chk("busy", 32'(bz[l]), 32'(ebusy));
          if (erv != 3'b000) chk("rdata", rd[l][eown], edata);
        end
        for (int p = 0; p < 3; p++) begin
          if (rq[p] && !gv[0][p]) begin
            wt[p]++;
            chk("fair_wait", (wt[p] <= BOUND - 1) ? 1 : 0, 1);
          end else begin
            wt[p] = 0;
          end
        end
        hv[cyc%8] = (win != 3) && !wr;
        hc[cyc%8] = cyc;
        ho[cyc%8] = win;
        hd[cyc%8] = mm[wi];
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (mem_wen[b]) mm[wi][8*b +: 8] = mem_wdata[8*b +: 8];
        end
        if (win != 3) last = win;
      end
      cyc++;
    end
  end

  initial begin
    logic [2:0]  sg;
    logic [31:0] r, r2;
    resetn = 1'b0; ram_load = 1'b1;
    if_req = 1'b1; mem_req = 1'b1; dbg_req = 1'b1;
    if_addr = '0; mem_addr = '0; dbg_addr = '0; mem_wen = 4'b0000; mem_wdata = '0;

    // Reset holds everything quiet even with all requests raised.
    repeat (3) @(negedge clk);
    ram_load = 1'b0;
    for (int l = 0; l < 2; l++) begin
      chk("t1_gnt", 32'(gv[l]), 0);
      chk("t1_ram_en", 32'(en[l]), 0);
      chk("t1_busy", 32'(bz[l]), 0);
    end
    @(posedge clk); #1 resetn = 1'b1;

    // Rotation with every request held.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t3_rr_order", own_of(gv[0]), DBG_EN ? (k % 3) : (k % 2));
      @(posedge clk); #1;
    end
    if_req = 1'b0; mem_req = 1'b0; dbg_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Single IF read of word 4.
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("t2_if_gnt", 32'(d1_if_gnt), 1);
    chk("t2_ram_addr", 32'(d1_addr), 4);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    chk("t2_if_rvalid_lat1", 32'(d1_if_rv), 1);
    chk("t2_if_rdata_lat1", d1_if_rd, 32'h12345678);
    chk("t2_other_rvalid", 32'({d1_dbg_rv, d1_mem_rv}), 0);
    chk("t2_if_rvalid_lat2_early", 32'(d2_if_rv), 0);
    @(negedge clk);
    chk("t2_if_rvalid_lat2", 32'(d2_if_rv), 1);
    chk("t2_if_rdata_lat2", d2_if_rd, 32'h12345678);
    @(posedge clk); #1;

    // Partial MEM write, then read it back through IF.
    mem_req = 1'b1; mem_addr = 32'h20; mem_wen = 4'b0011; mem_wdata = 32'hAABBCCDD;
    @(negedge clk);
    chk("t4_mem_gnt", 32'(d1_mem_gnt), 1);
    chk("t4_ram_wen", 32'(d1_wen), 32'h3);
    chk("t4_ram_addr", 32'(d1_addr), 8);
    @(posedge clk); #1 mem_req = 1'b0; mem_wen = 4'b0000;
    @(negedge clk);
    chk("t4_no_rvalid_lat1", 32'(d1_mem_rv), 0);
    @(negedge clk);
    chk("t4_no_rvalid_lat2", 32'(d2_mem_rv), 0);
    @(posedge clk); #1 if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk);
    @(posedge clk); #1 if_req = 1'b0;
    @(negedge clk);
    chk("t4_readback", d1_if_rd, 32'h1122CCDD);
    @(posedge clk); #1;

    // Reset one cycle after a read grant on the RAM_LAT=2 arbiter drops the read.
    if (DBG_EN) begin dbg_req = 1'b1; dbg_addr = 32'h40; end
    else begin if_req = 1'b1; if_addr = 32'h40; end
    @(negedge clk);
    chk("t5_gnt", own_of(gv[1]), DBG_EN ? 2 : 0);
    @(posedge clk); #1 dbg_req = 1'b0; if_req = 1'b0; resetn = 1'b0;
    @(negedge clk);
    chk("t5_busy_drop", 32'(d2_busy), 0);
    chk("t5_rvalid_a", 32'(rv[1]), 0);
    @(negedge clk);
    chk("t5_rvalid_b", 32'(rv[1]), 0);
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("t5_rvalid_c", 32'(rv[1]), 0);
    @(posedge clk); #1;

    // Randomised traffic with held requests, abandoned requests and reset pulses.
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      sg = gv[0];
      @(posedge clk); #1;
      if (!resetn) begin
        if ($urandom_range(0, 2) == 0) resetn = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        resetn = 1'b0;
      end
      if (sg[0] || !if_req) begin
        r = $urandom(); if_req = ($urandom_range(0, 2) != 0); if_addr = mkaddr(r);
      end else if ($urandom_range(0, 15) == 0) if_req = 1'b0;
      if (sg[1] || !mem_req) begin
        r = $urandom(); r2 = $urandom();
        mem_req = ($urandom_range(0, 2) != 0); mem_addr = mkaddr(r);
        mem_wen = r2[0] ? 4'b0000 : r2[4:1]; mem_wdata = $urandom();
      end else if ($urandom_range(0, 15) == 0) mem_req = 1'b0;
      if (sg[2] || !dbg_req) begin
        r = $urandom(); dbg_req = ($urandom_range(0, 2) != 0); dbg_addr = mkaddr(r);
      end else if ($urandom_range(0, 15) == 0) dbg_req = 1'b0;
    end

    resetn = 1'b1; if_req = 1'b0; mem_req = 1'b0; dbg_req = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
